// File: rtl/tank_layer_compositor.sv
// Two-stage pixel compositor for title, maze, two tanks and a bank of bullets.
// Each tank carries an ALIVE/FLASH/DEAD state machine that makes a shot tank blink and vanish.
module tank_layer_compositor #(
  parameter int          NUM_BULLETS  = 3,
  parameter int          HEAD_HALF    = 6,
  parameter int          FLASH_FRAMES = 8,
  parameter int          BLINK_FRAMES = 2,
  parameter logic [23:0] BG_RGB       = 24'h555555
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic                      blank,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      title,
  input  logic                      maze,
  input  logic [9:0]                Tank1X,
  input  logic [9:0]                Tank1Y,
  input  logic [9:0]                Tank2X,
  input  logic [9:0]                Tank2Y,
  input  logic [1:0]                Tank1Dir,
  input  logic [1:0]                Tank2Dir,
  input  logic [9:0]                TankSize,
  input  logic                      Tank1Shot,
  input  logic                      Tank2Shot,
  input  logic [10*NUM_BULLETS-1:0] BulletX,
  input  logic [10*NUM_BULLETS-1:0] BulletY,
  input  logic [10*NUM_BULLETS-1:0] BulletS,
  input  logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic                      Tank1Dead,
  output logic                      Tank2Dead
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [9:0] HH = 10'(HEAD_HALF);

  typedef enum logic [1:0] {ALIVE, FLASH, DEAD} tank_state_t;

  // Inclusive [c - lo_off, c + hi_off] in 11 bits: low end clamps at 0, high end never wraps.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] c,
                                   input logic [9:0] lo_off, input logic [9:0] hi_off);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = (c >= lo_off) ? ({1'b0, c} - {1'b0, lo_off}) : 11'd0;
    hi = {1'b0, c} + {1'b0, hi_off};
    return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
  endfunction

  logic [1:0][9:0] tank_x;
  logic [1:0][9:0] tank_y;
  logic [1:0][1:0] tank_dir;
  logic [1:0]      tank_shot;
  logic [1:0]      head_hit;
  logic [1:0]      body_hit;
  logic [1:0]      visible_vec;
  logic [1:0]      dead_vec;

  assign tank_x    = {Tank2X, Tank1X};
  assign tank_y    = {Tank2Y, Tank1Y};
  assign tank_dir  = {Tank2Dir, Tank1Dir};
  assign tank_shot = {Tank2Shot, Tank1Shot};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tank
      tank_state_t   state_reg, state_next;
      logic [CW-1:0] count_reg, count_next;
      logic [BW-1:0] blink_reg, blink_next;
      logic          phase_reg, phase_next;
      logic          shot_prev_reg;
      logic          dead_reg;
      logic          head_w;

      always_ff @(posedge CLK) begin
        if (Reset) begin
          state_reg     <= ALIVE;
          count_reg     <= '0;
          blink_reg     <= '0;
          phase_reg     <= 1'b1;
          // Track the live level so a shot held through reset is not seen as an edge.
          shot_prev_reg <= tank_shot[gi];
          dead_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          count_reg     <= count_next;
          blink_reg     <= blink_next;
          phase_reg     <= phase_next;
          shot_prev_reg <= tank_shot[gi];
          dead_reg      <= (state_reg == DEAD);
        end
      end

      always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        blink_next = blink_reg;
        phase_next = phase_reg;
        case (state_reg)
          ALIVE: begin
            if (tank_shot[gi] && !shot_prev_reg) begin
              state_next = FLASH;
              count_next = '0;
              blink_next = '0;
              phase_next = 1'b1;
            end
          end
          FLASH: begin
            if (frame_start) begin
              count_next = count_reg + CW'(1);
              if (count_reg == CW'(FLASH_FRAMES - 1)) state_next = DEAD;
              if (blink_reg == BW'(BLINK_FRAMES - 1)) begin
                blink_next = '0;
                phase_next = ~phase_reg;
              end else begin
                blink_next = blink_reg + BW'(1);
              end
            end
          end
          DEAD: begin
            if (!tank_shot[gi]) state_next = ALIVE;
          end
          default: state_next = ALIVE;
        endcase
      end

      always_comb begin
        head_w = 1'b0;
        case (tank_dir[gi])
          2'd0: head_w = in_span(DrawX, tank_x[gi], 10'd0, TankSize) &&
                         in_span(DrawY, tank_y[gi], HH, HH);
          2'd1: head_w = in_span(DrawY, tank_y[gi], 10'd0, TankSize) &&
                         in_span(DrawX, tank_x[gi], HH, HH);
          2'd2: head_w = in_span(DrawX, tank_x[gi], TankSize, 10'd0) &&
                         in_span(DrawY, tank_y[gi], HH, HH);
          default: head_w = in_span(DrawY, tank_y[gi], TankSize, 10'd0) &&
                            in_span(DrawX, tank_x[gi], HH, HH);
        endcase
      end

      assign head_hit[gi]    = head_w;
      assign body_hit[gi]    = in_span(DrawX, tank_x[gi], TankSize, TankSize) &&
                               in_span(DrawY, tank_y[gi], TankSize, TankSize);
      assign visible_vec[gi] = (state_reg == ALIVE) || ((state_reg == FLASH) && phase_reg);
      assign dead_vec[gi]    = dead_reg;
    end
  endgenerate

  logic [NUM_BULLETS-1:0] bullet_hit;

  generate
    for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bullet
      assign bullet_hit[gi] = bullet_active[gi] &&
        in_span(DrawX, BulletX[10*gi +: 10], BulletS[10*gi +: 10], BulletS[10*gi +: 10]) &&
        in_span(DrawY, BulletY[10*gi +: 10], BulletS[10*gi +: 10], BulletS[10*gi +: 10]);
    end
  endgenerate

  logic                   blank_reg;
  logic                   title_reg;
  logic                   maze_reg;
  logic [1:0]             head_reg;
  logic [1:0]             body_reg;
  logic [NUM_BULLETS-1:0] bullet_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      blank_reg  <= 1'b0;
      title_reg  <= 1'b0;
      maze_reg   <= 1'b0;
      head_reg   <= '0;
      body_reg   <= '0;
      bullet_reg <= '0;
    end else begin
      blank_reg  <= blank;
      title_reg  <= title;
      maze_reg   <= maze;
      head_reg   <= head_hit & visible_vec;
      body_reg   <= body_hit & visible_vec;
      bullet_reg <= bullet_hit;
    end
  end

  logic [23:0] rgb_reg;
  logic [23:0] rgb_next;

  // Every bullet draws black, so channel order only matters conceptually.
  always_comb begin
    rgb_next = BG_RGB;
    if (!blank_reg)        rgb_next = 24'h000000;
    else if (title_reg)    rgb_next = 24'hFFFFFF;
    else if (maze_reg)     rgb_next = 24'h000000;
    else if (head_reg[0])  rgb_next = 24'h00FFFF;
    else if (body_reg[0])  rgb_next = 24'hFFBB00;
    else if (|bullet_reg)  rgb_next = 24'h000000;
    else if (head_reg[1])  rgb_next = 24'h00FFFF;
    else if (body_reg[1])  rgb_next = 24'hFF0000;
  end

  always_ff @(posedge CLK) begin
    if (Reset) rgb_reg <= 24'h000000;
    else       rgb_reg <= rgb_next;
  end

  assign Red       = rgb_reg[23:16];
  assign Green     = rgb_reg[15:8];
  assign Blue      = rgb_reg[7:0];
  assign Tank1Dead = dead_vec[0];
  assign Tank2Dead = dead_vec[1];

endmodule

// File: tb/tb_tank_layer_compositor.sv
// Scoreboard bench for tank_layer_compositor: expected pixels are queued with a due cycle
// and checked by a monitor two cycles later; FSM outputs are checked inline by each scenario.
module tb_tank_layer_compositor;

  localparam int NB = 3;
  localparam logic [23:0] BG    = 24'h555555;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] HEAD  = 24'h00FFFF;
  localparam logic [23:0] BODY1 = 24'hFFBB00;
  localparam logic [23:0] BODY2 = 24'hFF0000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             Reset = 1'b1;
  logic             frame_start = 1'b0;
  logic             blank = 1'b1;
  logic [9:0]       DrawX = 10'd100, DrawY = 10'd100;
  logic             title = 1'b0, maze = 1'b0;
  logic [9:0]       Tank1X = 10'd200, Tank1Y = 10'd200;
  logic [9:0]       Tank2X = 10'd800, Tank2Y = 10'd800;
  logic [1:0]       Tank1Dir = 2'd0, Tank2Dir = 2'd0;
  logic [9:0]       TankSize = 10'd10;
  logic             Tank1Shot = 1'b0;
  logic             Tank2Shot = 1'b1;
  logic [10*NB-1:0] BulletX = '0, BulletY = '0, BulletS = '0;
  logic [NB-1:0]    bullet_active = '0;
  logic [7:0]       Red, Green, Blue;
  logic             Tank1Dead, Tank2Dead;

  tank_layer_compositor #(
    .NUM_BULLETS(NB), .HEAD_HALF(6), .FLASH_FRAMES(8), .BLINK_FRAMES(2), .BG_RGB(24'h555555)
  ) dut (
    .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .title(title), .maze(maze),
    .Tank1X(Tank1X), .Tank1Y(Tank1Y), .Tank2X(Tank2X), .Tank2Y(Tank2Y),
    .Tank1Dir(Tank1Dir), .Tank2Dir(Tank2Dir), .TankSize(TankSize),
    .Tank1Shot(Tank1Shot), .Tank2Shot(Tank2Shot),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .bullet_active(bullet_active),
    .Red(Red), .Green(Green), .Blue(Blue), .Tank1Dead(Tank1Dead), .Tank2Dead(Tank2Dead)
  );

  typedef struct {
    bit          valid;
    int          due;
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: compares the pixel whose inputs were applied two cycles earlier.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.valid && e.due == cyc) begin
        n_tests++;
        if ({Red, Green, Blue} !== e.exp) begin
          n_fail++;
          $display("FAIL %s: rgb=%06h expected %06h", e.name, {Red, Green, Blue}, e.exp);
        end else begin
          $display("[TB] %s rgb=%06h ok", e.name, {Red, Green, Blue});
        end
      end
    end
  end

  // Applies the current inputs for one cycle and queues what the DUT must show for them.
  task automatic step(input bit valid, input logic [23:0] exp, input string name);
    exp_t e;
    e.valid = valid;
    e.due   = cyc + 2;
    e.exp   = exp;
    e.name  = name;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step(1'b0, BLACK, "pulse");
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    DrawX = 10'd100; DrawY = 10'd100; blank = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, BLACK, $sformatf("reset_rgb_%0d", i));
    Reset = 1'b0;
    step(1'b1, BG, "bg_after_reset");
    step(1'b1, BG, "bg_after_reset_1");
    n_tests++;
    if (Tank1Dead !== 1'b0 || Tank2Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dead: Tank1Dead=%0b Tank2Dead=%0b expected 0 0", Tank1Dead, Tank2Dead);
    end
  endtask

  task automatic test_head_body();
    Tank1X = 10'd200; Tank1Y = 10'd200; Tank1Dir = 2'd0;
    DrawX = 10'd205; DrawY = 10'd200; step(1'b1, HEAD,  "dir0_head");
    DrawX = 10'd195;                  step(1'b1, BODY1, "dir0_body");
    DrawX = 10'd210; DrawY = 10'd206; step(1'b1, HEAD,  "dir0_head_corner");
    DrawX = 10'd211; DrawY = 10'd200; step(1'b1, BG,    "dir0_outside");
    DrawX = 10'd205; DrawY = 10'd207; step(1'b1, BODY1, "dir0_beyond_bar");
    Tank1Dir = 2'd2;
    DrawX = 10'd195; DrawY = 10'd200; step(1'b1, HEAD,  "dir2_head");
    DrawX = 10'd205;                  step(1'b1, BODY1, "dir2_body");
    Tank1Dir = 2'd1;
    DrawX = 10'd200; DrawY = 10'd205; step(1'b1, HEAD,  "dir1_head");
    DrawY = 10'd195;                  step(1'b1, BODY1, "dir1_body");
    Tank1Dir = 2'd3;                  step(1'b1, HEAD,  "dir3_head");
    DrawX = 10'd207;                  step(1'b1, BODY1, "dir3_beside_bar");
    Tank1Dir = 2'd0;
  endtask

  task automatic test_bullets();
    Tank2X = 10'd55; Tank2Y = 10'd55;
    BulletX[0 +: 10] = 10'd50;  BulletY[0 +: 10] = 10'd50;  BulletS[0 +: 10] = 10'd3;
    BulletX[10 +: 10] = 10'd300; BulletY[10 +: 10] = 10'd300; BulletS[10 +: 10] = 10'd2;
    BulletX[20 +: 10] = 10'd55;  BulletY[20 +: 10] = 10'd55;  BulletS[20 +: 10] = 10'd5;
    bullet_active = 3'b101;
    DrawX = 10'd50; DrawY = 10'd50; step(1'b1, BLACK, "bullets_0_2_over_tank2");
    bullet_active = 3'b000;         step(1'b1, BODY2, "bullets_off_tank2_body");
    DrawX = 10'd60; DrawY = 10'd55; step(1'b1, HEAD,  "tank2_head");
    bullet_active = 3'b001;
    DrawX = 10'd53; DrawY = 10'd50; step(1'b1, BLACK, "bullet0_edge_in");
    DrawX = 10'd54;                 step(1'b1, BODY2, "bullet0_edge_out");
    DrawX = 10'd50; DrawY = 10'd46; step(1'b1, BODY2, "bullet0_edge_out_y");
    bullet_active = 3'b000;
    Tank2X = 10'd800; Tank2Y = 10'd800;
    Tank1X = 10'd0; Tank1Y = 10'd0;
    DrawX = 10'd0;    DrawY = 10'd0;    step(1'b1, HEAD,  "corner_origin");
    DrawX = 10'd0;    DrawY = 10'd8;    step(1'b1, BODY1, "corner_body");
    DrawX = 10'd1023; DrawY = 10'd0;    step(1'b1, BG,    "no_wrap_x");
    DrawX = 10'd0;    DrawY = 10'd1023; step(1'b1, BG,    "no_wrap_y");
    Tank1X = 10'd200; Tank1Y = 10'd200;
  endtask

  task automatic test_flash();
    logic vis;
    DrawX = 10'd195; DrawY = 10'd200;
    Tank1Shot = 1'b0; step(1'b1, BODY1, "flash_idle");
    Tank1Shot = 1'b1; step(1'b1, BODY1, "flash_rise");
    step(1'b1, BODY1, "flash_after_0");
    for (int p = 1; p <= 8; p++) begin
      pulse();
      vis = (p < 8) && ((p / 2) % 2 == 0);
      step(1'b1, vis ? BODY1 : BG, $sformatf("flash_after_%0d", p));
      n_tests++;
      if (Tank1Dead !== ((p == 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL flash_dead_%0d: Tank1Dead=%0b expected %0b", p, Tank1Dead, (p == 8));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, BG, "dead_hold");
    n_tests++;
    if (Tank1Dead !== 1'b1) begin
      n_fail++;
      $display("FAIL dead_hold: Tank1Dead=%0b expected 1", Tank1Dead);
    end
    Tank1Shot = 1'b0;
    step(1'b1, BG, "dead_release");
    step(1'b1, BODY1, "alive_after_release");
    step(1'b1, BODY1, "alive_after_release_1");
    n_tests++;
    if (Tank1Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL alive_dead_flag: Tank1Dead=%0b expected 0", Tank1Dead);
    end
  endtask

  task automatic test_boundary();
    logic vis;
    DrawX = 10'd195; DrawY = 10'd200;
    Tank1Shot = 1'b1; frame_start = 1'b1;
    step(1'b1, BODY1, "rise_with_pulse");
    frame_start = 1'b0;
    for (int p = 1; p <= 7; p++) begin
      pulse();
      vis = ((p / 2) % 2 == 0);
      step(1'b1, vis ? BODY1 : BG, $sformatf("uncounted_after_%0d", p));
    end
    n_tests++;
    if (Tank1Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL uncounted_dead_7: Tank1Dead=%0b expected 0", Tank1Dead);
    end
    Tank1Shot = 1'b0;
    step(1'b1, BG, "release_in_flash");
    pulse();
    step(1'b1, BG, "dead_then_release");
    n_tests++;
    if (Tank1Dead !== 1'b1) begin
      n_fail++;
      $display("FAIL release_dead: Tank1Dead=%0b expected 1", Tank1Dead);
    end
    step(1'b1, BODY1, "alive_next_cycle");
    n_tests++;
    if (Tank1Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL release_alive: Tank1Dead=%0b expected 0", Tank1Dead);
    end
    Tank1Shot = 1'b1;
    step(1'b1, BODY1, "rise_b");
    for (int p = 1; p <= 3; p++) begin
      pulse();
      vis = ((p / 2) % 2 == 0);
      step(1'b1, vis ? BODY1 : BG, $sformatf("midflash_after_%0d", p));
    end
    step(1'b0, BLACK, "pre_reset");
    Reset = 1'b1;
    step(1'b1, BLACK, "reset_mid_flash");
    n_tests++;
    if (Tank1Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flash_dead: Tank1Dead=%0b expected 0", Tank1Dead);
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, BODY1, $sformatf("visible_after_reset_%0d", i));
    Tank1Shot = 1'b0;
    step(1'b1, BODY1, "shot_cleared");
    n_tests++;
    if (Tank2Dead !== 1'b0) begin
      n_fail++;
      $display("FAIL tank2_held_shot: Tank2Dead=%0b expected 0", Tank2Dead);
    end
  endtask

  task automatic test_priority();
    BulletX[0 +: 10] = 10'd200; BulletY[0 +: 10] = 10'd200; BulletS[0 +: 10] = 10'd3;
    bullet_active = 3'b001;
    DrawX = 10'd198; DrawY = 10'd200;
    title = 1'b1;  step(1'b1, WHITE, "title_over_tank_bullet");
    title = 1'b0; maze = 1'b1; step(1'b1, BLACK, "maze_over_tank");
    maze = 1'b0;   step(1'b1, BODY1, "tank1_over_bullet");
    blank = 1'b0; title = 1'b1; step(1'b1, BLACK, "blank_forces_black");
    blank = 1'b1; title = 1'b0;
    bullet_active = 3'b000;
    DrawX = 10'd805; DrawY = 10'd800; step(1'b1, HEAD,  "tank2_head_far");
    DrawX = 10'd795;                  step(1'b1, BODY2, "tank2_body_far");
    BulletX[10 +: 10] = 10'd805; BulletY[10 +: 10] = 10'd800; BulletS[10 +: 10] = 10'd2;
    bullet_active = 3'b010;
    DrawX = 10'd805;                  step(1'b1, BLACK, "bullet_over_tank2_head");
    bullet_active = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    DrawY = 10'd200; Tank1Dir = 2'd0;
    for (int x = 185; x <= 215; x++) begin
      DrawX = 10'(x);
      if (x >= 190 && x <= 199)      exp = BODY1;
      else if (x >= 200 && x <= 210) exp = HEAD;
      else                           exp = BG;
      step(1'b1, exp, $sformatf("sweep_x%0d", x));
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_head_body();
    test_bullets();
    test_flash();
    test_boundary();
    test_priority();
    test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b0, BLACK, "drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_layer_compositor.md
Name: tank_layer_compositor

Overview:
- Parametrised, pipelined successor to the game's per-pixel colour mapper.
- Composites title, maze, two tanks and NUM_BULLETS bullets into 24-bit RGB for the VGA path.
- Tanks are axis-aligned with a 4-way head direction.
- Each tank has a hit-flash state machine (ALIVE/FLASH/DEAD) stepped by a frame pulse, so a shot tank blinks before vanishing.

Parameters:
- NUM_BULLETS, 3, number of bullet channels (1..8).
- HEAD_HALF, 6, half-width of the tank head bar, in pixels.
- FLASH_FRAMES, 8, frames spent in FLASH before DEAD (>=1).
- BLINK_FRAMES, 2, frames per blink half-period (>=1).
- BG_RGB, 24'h555555, background colour.

Ports:
- CLK  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- blank  in  1  1 = active video.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- title, maze  in  1 each  title / maze-wall pixel flags.
- Tank1X, Tank1Y, Tank2X, Tank2Y  in  10 each  tank centres.
- Tank1Dir, Tank2Dir  in  2 each  head direction: 0 = right, 1 = down, 2 = left, 3 = up.
- TankSize  in  10  tank body half-size.
- Tank1Shot, Tank2Shot  in  1 each  level; 1 = tank has been hit.
- BulletX, BulletY, BulletS  in  10*NUM_BULLETS each  packed bullet centre and half-size; channel i occupies bits [10i+9:10i].
- bullet_active  in  NUM_BULLETS  per-channel enable.
- Red, Green, Blue  out  8 each  registered pixel colour.
- Tank1Dead, Tank2Dead  out  1 each  registered; 1 while the tank's FSM is in DEAD.

Behaviour:
- Reset: Red/Green/Blue = 0, Tank*Dead = 0, both FSMs = ALIVE, all pipeline registers cleared (delayed blank = 0).
- Pipeline, latency 2 cycles:
  - Stage 1 registers blank, title, maze, every region-hit bit and the tank-visible bits.
  - Stage 2 performs the priority mux into Red/Green/Blue.
  - Output at cycle n+2 corresponds to inputs at cycle n; full throughput, no stalls.
- Region arithmetic:
  - All bounds are computed in 11 bits; lower bound = max(0, c - r).
  - Upper bound c + r is not truncated, so regions never wrap at screen edges.
  - All ranges are inclusive.
- Body region: |DrawX - TX| <= TankSize and |DrawY - TY| <= TankSize.
- Head region:
  - Dir 0: X in [TX, TX+TankSize], Y in [TY-HEAD_HALF, TY+HEAD_HALF].
  - Dir 2: X in [TX-TankSize, TX], Y in [TY-HEAD_HALF, TY+HEAD_HALF].
  - Dir 1/3: the same bar transposed onto Y (down = +Y).
- Bullet i region: within BulletS[i] of its centre on both axes, and bullet_active[i] = 1.
- Priority, highest first:
  1. !blank -> 000000
  2. title -> FFFFFF
  3. maze -> 000000
  4. tank1 head -> 00FFFF
  5. tank1 body -> FFBB00
  6. any bullet (lowest index wins, all draw 000000)
  7. tank2 head -> 00FFFF
  8. tank2 body -> FF0000
  9. BG_RGB
- Tank FSM (one per tank, identical):
  - ALIVE: rising edge of TankShot (registered previous value) -> FLASH; frame count = 0, phase = visible.
  - FLASH: each frame_start increments the frame count. The phase toggles every BLINK_FRAMES pulses. When the count reaches FLASH_FRAMES -> DEAD.
  - DEAD: TankShot = 0 -> ALIVE; otherwise hold.
  - Visibility: ALIVE = visible; FLASH = visible only while phase = visible; DEAD = hidden. A hidden tank's head and body hits are forced to 0.
- Boundary conditions:
  - Shot rising edge and frame_start in the same cycle: enter FLASH; that pulse is not counted.
  - Shot deasserted during FLASH: FLASH still completes to DEAD, then returns to ALIVE on the next cycle.
  - Shot held high from reset: no rising edge seen, tank stays ALIVE.
  - Reset mid-FLASH: ALIVE immediately; Tank*Dead = 0 next cycle.
  - FSM state changes affect the visibility bits captured in stage 1 on the following cycle.
  - Tank*Dead is registered: asserted the cycle after the FSM enters DEAD.

Test Plan:
- Reset asserted, then DrawX = 100, DrawY = 100 with blank = 1, nothing present -> RGB = 000000 during reset; 555555 exactly 2 cycles after the inputs are applied.
- Tank1 at (200, 200), TankSize = 10, Dir = 0; probe (205, 200) -> 00FFFF; (195, 200) -> FFBB00. With Dir = 2: (195, 200) -> 00FFFF.
- NUM_BULLETS = 3: bullets 0 and 2 both cover (50, 50), bullet 2 also overlaps tank2 body; probe (50, 50) -> 000000; clear bullet_active -> FF0000. Tank1 at (0, 0): (0, 0) body hit, no wrap hit at (1023, 0).
- FLASH_FRAMES = 8, BLINK_FRAMES = 2: pulse Tank1Shot, then issue 8 frame_start pulses. Tank1 pixel visible after pulses 0-1, hidden after 2-3, visible after 4-5, hidden after 6-7. Tank1Dead = 1 one cycle after the 8th pulse; tank pixel then shows background.
- Tank1Shot rises in the same cycle as frame_start -> enters FLASH with count 0. Reset asserted at count 3 -> ALIVE and tank visible again within 3 cycles.
- title = 1 over a tank and a bullet -> FFFFFF; blank = 0 -> 000000 regardless of other inputs.
